// File: rtl/pin_walk_checker.sv
// Loopback checker for a one-hot walking pin pattern: synchronize, debounce, lock, track steps.
// Define PIN_WALK_CHECKER_TIMEOUT_EN to add the step-timeout watchdog (timeout_o tied low otherwise).
module pin_walk_checker #(
  parameter int NUM_PINS       = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [NUM_PINS-1:0]         pins_i,
  input  logic                        clear_i,
  output logic                        locked_o,
  output logic                        step_o,
  output logic [$clog2(NUM_PINS)-1:0] idx_o,
  output logic                        error_o,
  output logic [15:0]                 err_count_o,
  output logic                        timeout_o
);

  localparam int IDX_W = $clog2(NUM_PINS);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 2);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_e;

  if (NUM_PINS < 2)       $error("NUM_PINS must be >= 2");
  if (SETTLE_CYCLES < 1)  $error("SETTLE_CYCLES must be >= 1");
  if (TIMEOUT_CYCLES < 1) $error("TIMEOUT_CYCLES must be >= 1");

  state_e              state_q, state_d;
  logic [NUM_PINS-1:0] sync1_q, pins_s_q, prev_q, last_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d, held;
  logic [IDX_W-1:0]    idx_q, hot_idx, idx_next;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic                err_q, err_d, step_q;
  logic                settle, fresh, is_onehot;
  logic                do_lock, do_step, do_err, tmo_hit;

  // held counts cycles the current pins_s value has been stable, including this one.
  always_comb begin
    held   = (pins_s_q != prev_q) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    cnt_d  = (held > CNT_W'(SETTLE_CYCLES)) ? CNT_W'(SETTLE_CYCLES) : held;
    settle = (held == CNT_W'(SETTLE_CYCLES));
  end

  // NOTE: every flop uses <= so all registers see pre-edge values regardless of block order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q  <= '0;
      pins_s_q <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pins_i;
      pins_s_q <= sync1_q;
      prev_q   <= pins_s_q;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: defaults are assigned before the loop/case so no path leaves a variable unassigned (no latch).
  always_comb begin
    hot_idx = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (pins_s_q[i]) hot_idx = IDX_W'(i);
    end
    is_onehot = (pins_s_q != '0) && ((pins_s_q & (pins_s_q - NUM_PINS'(1))) == '0);
    idx_next  = (idx_q == IDX_W'(NUM_PINS - 1)) ? '0 : idx_q + IDX_W'(1);
    fresh     = settle && (pins_s_q != last_q);
  end

`ifdef PIN_WALK_CHECKER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_pulse_q;

  assign tmo_hit = (state_q == LOCKED) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Age restarts on lock, on every accepted step and whenever the walk is not locked.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tmo_q       <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      tmo_pulse_q <= tmo_hit && !fresh;
      if (state_q != LOCKED || do_step || tmo_hit) tmo_q <= '0;
      else                                         tmo_q <= tmo_q + TMO_W'(1);
    end
  end
  assign timeout_o = tmo_pulse_q;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= SEARCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    do_lock = 1'b0;
    do_step = 1'b0;
    do_err  = 1'b0;
    case (state_q)
      SEARCH: begin
        if (fresh && is_onehot) begin
          state_d = LOCKED;
          do_lock = 1'b1;
        end
      end
      LOCKED: begin
        if (fresh) begin
          if (is_onehot && hot_idx == idx_next) begin
            do_step = 1'b1;
          end else begin
            do_err  = 1'b1;
            state_d = SEARCH;
          end
        end else if (tmo_hit) begin
          do_err  = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    locked_o = (state_q == LOCKED);
  end

  // A coincident clear still leaves exactly the new error recorded.
  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (do_err) begin
      err_d     = 1'b1;
      err_cnt_d = clear_i ? 16'd1 : ((err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1);
    end else if (clear_i) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q    <= '0;
      idx_q     <= '0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      step_q    <= do_step;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      if (do_lock || do_step) begin
        idx_q  <= hot_idx;
        last_q <= pins_s_q;
      end else if (do_err && fresh) begin
        last_q <= pins_s_q;
      end
    end
  end

  assign step_o      = step_q;
  assign idx_o       = idx_q;
  assign error_o     = err_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_pin_walk_checker.sv
// Self-checking bench for pin_walk_checker: vector table, corner sequences and random walk vs. a run-length model.
module tb_pin_walk_checker;

  localparam int N = 8;
  localparam int S = 4;
  localparam int T = 100;
`ifdef PIN_WALK_CHECKER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_i, clear_i;
  logic [N-1:0] pins_i;
  logic         locked_o, step_o, error_o, timeout_o;
  logic [2:0]   idx_o;
  logic [15:0]  err_count_o;

  always #5 clk = ~clk;

  pin_walk_checker #(.NUM_PINS(N), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .reset_i(reset_i), .pins_i(pins_i), .clear_i(clear_i),
    .locked_o(locked_o), .step_o(step_o), .idx_o(idx_o), .error_o(error_o),
    .err_count_o(err_count_o), .timeout_o(timeout_o)
  );

  int n_pass  = 0;
  int n_total = 0;
  int steps_seen, tmo_seen;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Model: pins_s is the input delayed two edges; a value settles when its run length hits S.
  logic [N-1:0] m_s1, m_cur, m_last;
  int           m_run, m_idx, m_cnt, m_age;
  bit           m_locked, m_step, m_tmo, m_err;

  task automatic model_edge();
    logic [N-1:0] v, nxt;
    bit settle, err_ev;
    if (reset_i) begin
      m_s1 = '0; m_cur = '0; m_run = 1; m_last = '0; m_locked = 0; m_step = 0;
      m_tmo = 0; m_err = 0; m_idx = 0; m_cnt = 0; m_age = 0;
      return;
    end
    v = m_cur; settle = (m_run == S); err_ev = 0; m_step = 0; m_tmo = 0;
    if (settle && v != m_last) begin
      if (!m_locked) begin
        if ($countones(v) == 1) begin m_locked = 1; m_idx = $clog2(v); m_last = v; m_age = 0; end
      end else if ($countones(v) == 1 && $clog2(v) == (m_idx + 1) % N) begin
        m_step = 1; m_idx = $clog2(v); m_last = v; m_age = 0;
      end else begin
        err_ev = 1; m_locked = 0; m_last = v;
      end
    end else if (m_locked) begin
      m_age++;
      if (TMO_EN && m_age == T) begin m_tmo = 1; err_ev = 1; m_locked = 0; end
    end
    if (err_ev) begin
      m_err = 1;
      m_cnt = clear_i ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
    end else if (clear_i) begin
      m_err = 0; m_cnt = 0;
    end
    nxt   = m_s1;
    m_s1  = pins_i;
    m_run = (nxt == m_cur) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
    m_cur = nxt;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("locked", 32'(locked_o), 32'(m_locked));
    check("step", 32'(step_o), 32'(m_step));
    check("idx", 32'(idx_o), 32'(m_idx));
    check("error", 32'(error_o), 32'(m_err));
    check("err_count", 32'(err_count_o), 32'(m_cnt));
    check("timeout", 32'(timeout_o), 32'(m_tmo));
    steps_seen += 32'(step_o);
    tmo_seen   += 32'(timeout_o);
  endtask

  task automatic hold(input logic [N-1:0] v, input int n);
    pins_i = v;
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    reset_i = 1'b1; pins_i = '0;
    cyc();
    reset_i = 1'b0;
    steps_seen = 0; tmo_seen = 0;
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] pins;
    bit           locked;
    int           idx;
    int           cnt;
    bit           err;
    int           steps;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int s0, p;
    logic [N-1:0] v;
    tbl[0]  = '{1'b1, 8'h01, 1'b1, 0, 0, 1'b0, 0};
    tbl[1]  = '{1'b0, 8'h02, 1'b1, 1, 0, 1'b0, 1};
    tbl[2]  = '{1'b0, 8'h04, 1'b1, 2, 0, 1'b0, 1};
    tbl[3]  = '{1'b0, 8'h08, 1'b1, 3, 0, 1'b0, 1};
    tbl[4]  = '{1'b0, 8'h10, 1'b1, 4, 0, 1'b0, 1};
    tbl[5]  = '{1'b0, 8'h20, 1'b1, 5, 0, 1'b0, 1};
    tbl[6]  = '{1'b0, 8'h40, 1'b1, 6, 0, 1'b0, 1};
    tbl[7]  = '{1'b0, 8'h80, 1'b1, 7, 0, 1'b0, 1};
    tbl[8]  = '{1'b0, 8'h01, 1'b1, 0, 0, 1'b0, 1};
    tbl[9]  = '{1'b1, 8'h04, 1'b1, 2, 0, 1'b0, 0};
    tbl[10] = '{1'b0, 8'h10, 1'b0, 2, 1, 1'b1, 0};
    tbl[11] = '{1'b0, 8'h20, 1'b1, 5, 1, 1'b1, 0};

    reset_i = 1'b1; clear_i = 1'b0; pins_i = '0;
    steps_seen = 0; tmo_seen = 0;
    cyc();
    check("rst_locked", 32'(locked_o), 32'd0);
    check("rst_idx", 32'(idx_o), 32'd0);
    check("rst_err_count", 32'(err_count_o), 32'd0);
    reset_i = 1'b0;

    // First lock lands five edges after the first edge that samples the new value.
    do_reset();
    pins_i = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 5) check("latency_before", 32'(locked_o), 32'd0);
      if (k == 6) check("latency_lock", 32'(locked_o), 32'd1);
    end
    check("latency_no_step", 32'(steps_seen), 32'd0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) do_reset();
      s0 = steps_seen;
      hold(tbl[i].pins, 10);
      check("vec_locked", 32'(locked_o), 32'(tbl[i].locked));
      check("vec_idx", 32'(idx_o), 32'(tbl[i].idx));
      check("vec_err_count", 32'(err_count_o), 32'(tbl[i].cnt));
      check("vec_error", 32'(error_o), 32'(tbl[i].err));
      check("vec_steps", 32'(steps_seen - s0), 32'(tbl[i].steps));
    end

    // Glitch back to the accepted value is harmless; a multi-hot value is an error.
    do_reset();
    hold(8'h04, 10);
    hold(8'h08, 2);
    hold(8'h04, 10);
    check("glitch_steps", 32'(steps_seen), 32'd0);
    check("glitch_err", 32'(err_count_o), 32'd0);
    check("glitch_locked", 32'(locked_o), 32'd1);
    hold(8'h18, 10);
    check("multihot_cnt", 32'(err_count_o), 32'd1);
    check("multihot_locked", 32'(locked_o), 32'd0);
    hold(8'h20, 10);
    check("relock_idx", 32'(idx_o), 32'd5);
    pins_i = 8'h01;
    repeat (5) cyc();
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    check("clear_err_cnt", 32'(err_count_o), 32'd1);
    check("clear_err_flag", 32'(error_o), 32'd1);
    hold(8'h02, 10);
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    check("clear_only_cnt", 32'(err_count_o), 32'd0);
    check("clear_only_locked", 32'(locked_o), 32'd1);
    check("clear_only_idx", 32'(idx_o), 32'd1);

    // Watchdog: a lock held with no steps.
    do_reset();
    if (TMO_EN) begin
      hold(8'h01, 150);
      check("tmo_pulses", 32'(tmo_seen), 32'd1);
      check("tmo_cnt", 32'(err_count_o), 32'd1);
      check("tmo_locked", 32'(locked_o), 32'd0);
    end else begin
      hold(8'h01, 1000);
      check("notmo_pulses", 32'(tmo_seen), 32'd0);
      check("notmo_cnt", 32'(err_count_o), 32'd0);
    end

    // Random walk with junk values, clears and resets.
    do_reset();
    p = 0;
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      if ($urandom_range(0, 9) < 7) begin
        p = (p + 1) % N;
        v = N'(1) << p;
      end else begin
        v = N'($urandom_range(0, 255));
      end
      pins_i = v;
      for (int c = 0, n = $urandom_range(1, 9); c < n; c++) begin
        clear_i = ($urandom_range(0, 9) == 0);
        cyc();
      end
      clear_i = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pin_walk_checker.md
PIN_WALK_CHECKER -- requirements
Module: pin_walk_checker

Interface
REQ-001 Parameter NUM_PINS, default 8: width of the checked pin bus; SHALL be >= 2.
REQ-002 Parameter SETTLE_CYCLES, default 4: consecutive stable synchronized cycles required before a pin value is evaluated; SHALL be >= 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 50_000_000: maximum cycles between accepted steps while locked; used only with the macro in REQ-025.
REQ-004 clk_i  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 pins_i  input  NUM_PINS  asynchronous loopback of a one-hot walking pin pattern.
REQ-007 clear_i  input  1  clears error_o and err_count_o.
REQ-008 locked_o  output  1  high while tracking a valid walk.
REQ-009 step_o  output  1  one-cycle pulse per correctly accepted step.
REQ-010 idx_o  output  $clog2(NUM_PINS)  index of the last accepted one-hot bit.
REQ-011 error_o  output  1  sticky error flag.
REQ-012 err_count_o  output  16  error count, saturating at 16'hFFFF.
REQ-013 timeout_o  output  1  one-cycle pulse on a step timeout.

Function
REQ-014 pins_i SHALL pass through a 2-flop synchronizer to give pins_s; a stable counter SHALL reset on any pins_s change and otherwise increment, saturating.
REQ-015 A settle event SHALL fire exactly once per distinct pins_s value, when that value has held for SETTLE_CYCLES cycles; registered outputs SHALL respond SETTLE_CYCLES+1 edges after the first edge sampling the new pins_i.
REQ-016 A settle value equal to the last accepted value SHALL be ignored, so glitches returning to the same value are harmless.
REQ-017 FSM states: SEARCH and LOCKED; reset state is SEARCH.
REQ-018 SEARCH: a one-hot settle value SHALL move to LOCKED, load idx_o, set locked_o, and SHALL NOT pulse step_o. A zero or multi-hot value SHALL be ignored with no error.
REQ-019 LOCKED: a one-hot value with index == (idx_o+1) mod NUM_PINS SHALL pulse step_o and update idx_o; NUM_PINS-1 -> 0 is valid.
REQ-020 LOCKED: any other settle value (wrong index, zero, or multi-hot) SHALL:
- increment err_count_o (saturating);
- set error_o;
- clear locked_o;
- return to SEARCH.
The offending value SHALL NOT relock; the next distinct settle value is evaluated in SEARCH.
REQ-021 clear_i SHALL zero error_o and err_count_o next cycle without affecting FSM or idx_o. If clear_i coincides with a new error, the result SHALL be error_o=1, err_count_o=1.
REQ-022 idx_o SHALL hold its value in SEARCH.

Reset
REQ-023 On reset_i, the following SHALL be zero/low on the next edge: sync flops, pins_s history, stable counter, last-accepted value, all outputs, state SEARCH, and the timeout counter.
REQ-024 Reset mid-walk SHALL discard lock; the first one-hot settle value after reset SHALL relock without error.

Configuration
REQ-025 With PIN_WALK_CHECKER_TIMEOUT_EN defined:
- in LOCKED, a counter SHALL count cycles since the last lock or accepted step;
- on reaching TIMEOUT_CYCLES it SHALL pulse timeout_o and apply the REQ-020 error actions.
Without the macro, the counter SHALL be absent and timeout_o SHALL be tied 0.

Verification
REQ-026 NUM_PINS=8, SETTLE_CYCLES=4: reset, then hold pins_i=8'h01 -> locked_o=1, idx_o=0 five edges after first sampling edge; step_o stays 0; error_o=0.
REQ-027 Walk 01,02,04,...,80,01, each held 10 cycles, after lock -> 8 step_o pulses; idx_o 7 -> 0 on wrap; err_count_o=0.
REQ-028 Locked at 8'h04, drive 8'h10 -> err_count_o=1, error_o=1, locked_o=0; then 8'h20 -> locked_o=1, idx_o=5, no step_o.
REQ-029 Locked at 8'h04, glitch 8'h08 for 2 cycles back to 8'h04 -> no step, no error; then hold 8'h18 -> err_count_o=1; then clear_i together with a new error -> err_count_o=1, error_o=1.
REQ-030 Timeout, TIMEOUT_CYCLES=100:
- with macro: lock at 8'h01, hold 100 cycles -> one timeout_o pulse, err_count_o=1, locked_o=0;
- without macro: hold 1000 cycles -> timeout_o=0, err_count_o=0.
